// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and the sync region type.
// Shared by vga_sync_gen (optional test pattern: VGA_TEST_PATTERN_EN).
package vga_pkg;

  typedef enum logic [1:0] {
    ACT,
    FRONT,
    SYNC,
    BACK
  } sync_state_t;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL =
    VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL =
    VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int VGA_HW = $clog2(VGA_H_TOTAL);
  localparam int VGA_VW = $clog2(VGA_V_TOTAL);

  localparam int RGB_W = 12;

endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster timing bundle from the sync generator
// to the pixel/colour stage.
interface vga_sync_gen_if
  import vga_pkg::*;
#(
  parameter int HW = VGA_HW,
  parameter int VW = VGA_VW
);

  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [HW-1:0]    pixel_x;
  logic [VW-1:0]    pixel_y;
  logic             frame_start;
  logic [RGB_W-1:0] rgb;

  modport master (
    output hsync,
    output vsync,
    output video_on,
    output pixel_x,
    output pixel_y,
    output frame_start,
    output rgb
  );

  modport slave (
    input hsync,
    input vsync,
    input video_on,
    input pixel_x,
    input pixel_y,
    input frame_start,
    input rgb
  );

endinterface

// File: rtl/vga_axis_fsm.sv
// vga_axis_fsm: one raster axis, a position counter plus its
// ACT/FRONT/SYNC/BACK region, advanced only when step is high.
module vga_axis_fsm
  import vga_pkg::*;
#(
  parameter int W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic [W-1:0] len_act,
  input  logic [W-1:0] len_fp,
  input  logic [W-1:0] len_sync,
  input  logic [W-1:0] len_bp,
  output logic [W-1:0] count,
  output sync_state_t state,
  output logic        wrap
);

  logic [W-1:0] e_act;
  logic [W-1:0] e_fp;
  logic [W-1:0] e_sync;
  logic [W-1:0] e_bp;
  logic [W-1:0] count_nx;
  sync_state_t  state_nx;

  // Last position of each region; the region switches on the
  // same edge the counter leaves it, so state tracks count.
  assign e_act  = len_act - W'(1);
  assign e_fp   = len_act + len_fp - W'(1);
  assign e_sync = len_act + len_fp + len_sync - W'(1);
  assign e_bp   = len_act + len_fp + len_sync + len_bp - W'(1);

  assign wrap = step && (count == e_bp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      state <= ACT;
    end else begin
      count <= count_nx;
      state <= state_nx;
    end
  end

  always_comb begin
    count_nx = count;
    state_nx = state;
    if (step) begin
      count_nx = wrap ? '0 : count + W'(1);
      unique case (state)
        ACT:   if (count == e_act)  state_nx = FRONT;
        FRONT: if (count == e_fp)   state_nx = SYNC;
        SYNC:  if (count == e_sync) state_nx = BACK;
        BACK:  if (wrap)            state_nx = ACT;
        default: state_nx = ACT;
      endcase
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing with registered, aligned outputs.
// Define VGA_TEST_PATTERN_EN for the 8-bar colour test pattern.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input logic            clk,
  input logic            rst,
  vga_sync_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  sync_state_t   h_st;
  sync_state_t   v_st;
  logic          h_wrap;
  logic          v_wrap;
  logic          vid;

  vga_axis_fsm #(.W(HW)) u_h (
    .clk      (clk),
    .rst      (rst),
    .step     (1'b1),
    .len_act  (HW'(H_ACTIVE)),
    .len_fp   (HW'(H_FP)),
    .len_sync (HW'(H_SYNC)),
    .len_bp   (HW'(H_BP)),
    .count    (h_cnt),
    .state    (h_st),
    .wrap     (h_wrap)
  );

  vga_axis_fsm #(.W(VW)) u_v (
    .clk      (clk),
    .rst      (rst),
    .step     (h_wrap),
    .len_act  (VW'(V_ACTIVE)),
    .len_fp   (VW'(V_FP)),
    .len_sync (VW'(V_SYNC)),
    .len_bp   (VW'(V_BP)),
    .count    (v_cnt),
    .state    (v_st),
    .wrap     (v_wrap)
  );

  assign vid = (h_st == ACT) && (v_st == ACT);

  logic          hs_q;
  logic          vs_q;
  logic          von_q;
  logic          fs_q;
  logic          org_q;
  logic [HW-1:0] px_q;
  logic [VW-1:0] py_q;

  // org_q marks that the counters sit at (0,0): out of reset
  // or right after the frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      von_q <= 1'b0;
      fs_q  <= 1'b0;
      org_q <= 1'b1;
      px_q  <= '0;
      py_q  <= '0;
    end else begin
      hs_q  <= (h_st == SYNC) ? HS_POL : ~HS_POL;
      vs_q  <= (v_st == SYNC) ? VS_POL : ~VS_POL;
      von_q <= vid;
      fs_q  <= org_q;
      org_q <= v_wrap;
      px_q  <= h_cnt;
      py_q  <= v_cnt;
    end
  end

  assign vif.hsync       = hs_q;
  assign vif.vsync       = vs_q;
  assign vif.video_on    = von_q;
  assign vif.frame_start = fs_q;
  assign vif.pixel_x     = px_q;
  assign vif.pixel_y     = py_q;

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]       bar;
  logic [RGB_W-1:0] rgb_q;

  assign bar = 3'(h_cnt / HW'(BAR_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
    end else if (vid) begin
      rgb_q <= {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
    end else begin
      rgb_q <= '0;
    end
  end

  assign vif.rgb = rgb_q;
`else
  assign vif.rgb = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: full-size and shrunken-timing instances checked
// against a pixel-index model, vector table and random async resets.
module tb_vga_sync_gen;
  import vga_pkg::*;

  localparam int SA  = 16;
  localparam int SF  = 2;
  localparam int SS  = 3;
  localparam int SB  = 3;
  localparam int TA  = 6;
  localparam int TF  = 1;
  localparam int TS  = 2;
  localparam int TB  = 2;
  localparam int SHT = SA + SF + SS + SB;
  localparam int SVT = TA + TF + TS + TB;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  typedef struct {
    int          x;
    int          y;
    bit          hs;
    bit          vs;
    bit          von;
    bit          fs;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    int          k;
    int          x;
    int          y;
    bit          hs;
    bit          von;
    bit          fs;
    logic [11:0] pat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k;
  int   n_cmp = 0;
  int   n_err = 0;

  always #20 clk = ~clk;

  // k = number of clock edges since reset was released
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  vga_sync_gen_if dif ();
  vga_sync_gen_if #(.HW($clog2(SHT)), .VW($clog2(SVT))) sif ();

  vga_sync_gen dut (
    .clk (clk),
    .rst (rst),
    .vif (dif.master)
  );

  vga_sync_gen #(
    .H_ACTIVE (SA), .H_FP (SF), .H_SYNC (SS), .H_BP (SB),
    .V_ACTIVE (TA), .V_FP (TF), .V_SYNC (TS), .V_BP (TB),
    .HS_POL   (1'b1), .VS_POL (1'b0)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .vif (sif.master)
  );

  function automatic exp_t model(
    int kk, int a, int f, int s, int b,
    int va, int vf, int vs, int vb, bit hp, bit vp);
    exp_t e;
    int   ht;
    int   vt;
    int   idx;
    int   bar;
    ht = a + f + s + b;
    vt = va + vf + vs + vb;
    e.x = 0; e.y = 0;
    e.hs = !hp; e.vs = !vp;
    e.von = 1'b0; e.fs = 1'b0; e.rgb = '0;
    if (kk == 0) return e;
    idx = kk - 1;
    e.x = idx % ht;
    e.y = (idx / ht) % vt;
    if (e.x >= a + f && e.x < a + f + s) e.hs = hp;
    if (e.y >= va + vf && e.y < va + vf + vs) e.vs = vp;
    e.von = (e.x < a) && (e.y < va);
    e.fs = (e.x == 0) && (e.y == 0);
    bar = e.x / (a / 8);
    if (PAT && e.von)
      e.rgb = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
    return e;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", nm, act, exp, k);
    end
  endtask

  task automatic check_both(string tag);
    exp_t d;
    exp_t s;
    d = model(k, VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP,
              VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP, 1'b0, 1'b0);
    s = model(k, SA, SF, SS, SB, TA, TF, TS, TB, 1'b1, 1'b0);
    cmp({tag, ".d.x"},   dif.pixel_x,     d.x);
    cmp({tag, ".d.y"},   dif.pixel_y,     d.y);
    cmp({tag, ".d.hs"},  dif.hsync,       d.hs);
    cmp({tag, ".d.vs"},  dif.vsync,       d.vs);
    cmp({tag, ".d.von"}, dif.video_on,    d.von);
    cmp({tag, ".d.fs"},  dif.frame_start, d.fs);
    cmp({tag, ".d.rgb"}, dif.rgb,         d.rgb);
    cmp({tag, ".s.x"},   sif.pixel_x,     s.x);
    cmp({tag, ".s.y"},   sif.pixel_y,     s.y);
    cmp({tag, ".s.hs"},  sif.hsync,       s.hs);
    cmp({tag, ".s.vs"},  sif.vsync,       s.vs);
    cmp({tag, ".s.von"}, sif.video_on,    s.von);
    cmp({tag, ".s.fs"},  sif.frame_start, s.fs);
    cmp({tag, ".s.rgb"}, sif.rgb,         s.rgb);
  endtask

  vec_t tv[13];

  initial begin
    int lows, first, von;
    int shs, shs_first, svs, svs_first, ymax, fsn, lx, ly;
    int guard, d;

    tv[0]  = '{1,   0,   0, 1, 1, 1, 12'h000};
    tv[1]  = '{2,   1,   0, 1, 1, 0, 12'h000};
    tv[2]  = '{80,  79,  0, 1, 1, 0, 12'h000};
    tv[3]  = '{81,  80,  0, 1, 1, 0, 12'h00F};
    tv[4]  = '{561, 560, 0, 1, 1, 0, 12'hFFF};
    tv[5]  = '{640, 639, 0, 1, 1, 0, 12'hFFF};
    tv[6]  = '{641, 640, 0, 1, 0, 0, 12'h000};
    tv[7]  = '{656, 655, 0, 1, 0, 0, 12'h000};
    tv[8]  = '{657, 656, 0, 0, 0, 0, 12'h000};
    tv[9]  = '{752, 751, 0, 0, 0, 0, 12'h000};
    tv[10] = '{753, 752, 0, 1, 0, 0, 12'h000};
    tv[11] = '{800, 799, 0, 1, 0, 0, 12'h000};
    tv[12] = '{801, 0,   1, 1, 1, 0, 12'h000};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    cmp("rst.hsync", dif.hsync, 1);
    cmp("rst.vsync", dif.vsync, 1);
    cmp("rst.von",   dif.video_on, 0);
    cmp("rst.s.hsync", sif.hsync, 0);
    check_both("rst");
    rst = 1'b0;

    foreach (tv[i]) begin
      guard = 0;
      while (k < tv[i].k && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      cmp($sformatf("tv%0d.x", i),   dif.pixel_x,     tv[i].x);
      cmp($sformatf("tv%0d.y", i),   dif.pixel_y,     tv[i].y);
      cmp($sformatf("tv%0d.hs", i),  dif.hsync,       tv[i].hs);
      cmp($sformatf("tv%0d.vs", i),  dif.vsync,       1);
      cmp($sformatf("tv%0d.von", i), dif.video_on,    tv[i].von);
      cmp($sformatf("tv%0d.fs", i),  dif.frame_start, tv[i].fs);
      cmp($sformatf("tv%0d.rgb", i), dif.rgb,
          PAT ? tv[i].pat : 12'h000);
    end

    // one full line starting at x=0, y=1
    lows = 0; first = -1; von = 0;
    for (int i = 0; i < 800; i++) begin
      if (dif.hsync === 1'b0) begin
        if (first < 0) first = i;
        lows++;
      end
      if (dif.video_on === 1'b1) von++;
      @(negedge clk);
    end
    cmp("line.hs_width", lows, 96);
    cmp("line.hs_start", first, 656);
    cmp("line.von_width", von, 640);
    cmp("line.period_x", dif.pixel_x, 0);
    cmp("line.period_y", dif.pixel_y, 2);

    // asynchronous reset in the middle of a line
    guard = 0;
    while (k < 1901 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    cmp("mid.x", dif.pixel_x, 300);
    cmp("mid.y", dif.pixel_y, 2);
    #7 rst = 1'b1;
    #1;
    cmp("async.x",   dif.pixel_x, 0);
    cmp("async.y",   dif.pixel_y, 0);
    cmp("async.von", dif.video_on, 0);
    cmp("async.hs",  dif.hsync, 1);
    check_both("async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cmp("restart.fs",  dif.frame_start, 1);
    cmp("restart.x",   dif.pixel_x, 0);
    cmp("restart.y",   dif.pixel_y, 0);
    cmp("restart.von", dif.video_on, 1);

    // one complete frame of the shrunken instance
    shs = 0; shs_first = -1; svs = 0; svs_first = -1;
    ymax = 0; fsn = 0; lx = -1; ly = -1;
    for (int i = 0; i < SHT * SVT; i++) begin
      if (i < SHT && sif.hsync === 1'b1) begin
        if (shs_first < 0) shs_first = i;
        shs++;
      end
      if (sif.vsync === 1'b0) begin
        if (svs_first < 0) svs_first = i;
        svs++;
      end
      if (int'(sif.pixel_y) > ymax) ymax = int'(sif.pixel_y);
      if (sif.frame_start === 1'b1) fsn++;
      lx = int'(sif.pixel_x);
      ly = int'(sif.pixel_y);
      @(negedge clk);
    end
    cmp("sf.hs_width",  shs, SS);
    cmp("sf.hs_start",  shs_first, SA + SF);
    cmp("sf.vs_width",  svs, TS * SHT);
    cmp("sf.vs_start",  svs_first, (TA + TF) * SHT);
    cmp("sf.ymax",      ymax, SVT - 1);
    cmp("sf.fs_count",  fsn, 1);
    cmp("sf.last_x",    lx, SHT - 1);
    cmp("sf.last_y",    ly, SVT - 1);
    cmp("sf.wrap_fs",   sif.frame_start, 1);
    cmp("sf.wrap_x",    sif.pixel_x, 0);
    cmp("sf.wrap_y",    sif.pixel_y, 0);

    // random run lengths with randomly timed asynchronous resets
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(1, 700)) begin
        @(negedge clk);
        check_both("rnd");
      end
      d = $urandom_range(1, 36);
      if (d >= 19) d += 2;
      #(d) rst = 1'b1;
      #1;
      check_both("rrst");
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      rst = 1'b0;
    end
    @(negedge clk);
    check_both("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
